// File: rtl/pc_redirect_controller.sv
// ---------------------------------------------------------------------------
// pc_redirect_controller
//
// Purpose:
//   Owns the IF-stage program counter and sequences every change to it:
//   - sequential +4 advance
//   - hold on a hazard stall or an instruction-memory wait
//   - redirects requested by the branch/jump unit
//   An applied redirect loads the PC and raises IF/ID and ID/EX flush pulses
//   for FLUSH_CYCLES cycles. While those pulses drain, further redirect
//   requests are ignored, so a held request cannot re-trigger.
//
// Ports:
//   CLK             in   system clock, rising edge
//   RESET           in   asynchronous active-low reset
//   stall           in   hazard-unit stall, hold PC
//   imem_busy       in   instruction memory not ready, hold PC
//   redirect_valid  in   redirect request from the branch/jump unit
//   redirect_target in   [31:0] redirect target address
//   PC              out  [31:0] current fetch address (registered)
//   pc_write_en     out  PC changes on the next edge (combinational)
//   if_id_flush     out  flush IF/ID register (registered)
//   id_ex_flush     out  flush ID/EX register (registered)
//   misalign_exc    out  one-cycle pulse on a misaligned redirect target
//   state_dbg       out  [1:0] FSM state: RUN=0, WAIT_MEM=1, FLUSH=2
//   redirect_count  out  [31:0] number of applied redirects
//
// Optional feature:
//   REDIRECT_PERF_CNT_EN - when defined, redirect_count is a saturating
//   counter of applied redirects. When undefined, it is tied to zero.
// ---------------------------------------------------------------------------
module pc_redirect_controller #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        stall,
   input  logic        imem_busy,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] PC,
   output logic        pc_write_en,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        misalign_exc,
   output logic [1:0]  state_dbg,
   output logic [31:0] redirect_count
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   // The counter is loaded with FLUSH_CYCLES-1, so the flushes stay high
   // for FLUSH_CYCLES cycles including the one in which it reaches zero.
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_pending;
   logic [2:0]  r_cnt;
   logic        r_if_id_flush;
   logic        r_id_ex_flush;
   logic        r_misalign;

   logic        w_apply;
   logic [31:0] w_apply_tgt;
   logic        w_misalign;
   logic [31:0] w_next_pc;
   logic        w_pc_write_en;

   // Next-PC selection and redirect-apply decode for the current state.
   always_comb begin
      w_apply     = 1'b0;
      w_apply_tgt = redirect_target;
      w_next_pc   = r_pc;
      case (r_state)
         ST_RUN: begin
            // A redirect beats a stall: the stalled instruction is younger
            // and gets flushed anyway.
            if (redirect_valid && !imem_busy) begin
               w_apply = 1'b1;
            end else if (redirect_valid || stall || imem_busy) begin
               w_next_pc = r_pc;
            end else begin
               w_next_pc = r_pc + 32'd4;
            end
         end
         ST_WAIT_MEM: begin
            if (!imem_busy) begin
               w_apply = 1'b1;
               // Latest request wins, even on the cycle memory frees up.
               w_apply_tgt = redirect_valid ? redirect_target : r_pending;
            end else begin
               w_next_pc = r_pc;
            end
         end
         ST_FLUSH: begin
            if (stall || imem_busy) begin
               w_next_pc = r_pc;
            end else begin
               w_next_pc = r_pc + 32'd4;
            end
         end
         default: begin
            w_next_pc = r_pc;
         end
      endcase

      w_misalign = w_apply && (w_apply_tgt[1:0] != 2'b00);
      if (w_apply) begin
         w_next_pc = w_misalign ? TRAP_VECTOR : w_apply_tgt;
      end else begin
         w_next_pc = w_next_pc;
      end

      if (r_state == ST_WAIT_MEM) begin
         w_pc_write_en = w_apply;
      end else begin
         w_pc_write_en = (w_next_pc != r_pc);
      end
   end

   // Controller FSM: PC, pending target, flush counter and flush/exception outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state       <= ST_RUN;
         r_pc          <= RESET_VECTOR;
         r_pending     <= 32'd0;
         r_cnt         <= 3'd0;
         r_if_id_flush <= 1'b0;
         r_id_ex_flush <= 1'b0;
         r_misalign    <= 1'b0;
      end else begin
         r_pc       <= w_next_pc;
         r_misalign <= w_misalign;
         if (w_apply) begin
            r_state       <= ST_FLUSH;
            r_cnt         <= FLUSH_LOAD;
            r_if_id_flush <= 1'b1;
            r_id_ex_flush <= 1'b1;
         end else begin
            case (r_state)
               ST_RUN: begin
                  // Apply was blocked by imem_busy: park the target.
                  if (redirect_valid) begin
                     r_pending <= redirect_target;
                     r_state   <= ST_WAIT_MEM;
                  end else begin
                     r_state <= ST_RUN;
                  end
                  r_if_id_flush <= 1'b0;
                  r_id_ex_flush <= 1'b0;
               end
               ST_WAIT_MEM: begin
                  if (redirect_valid) begin
                     r_pending <= redirect_target;
                  end else begin
                     r_pending <= r_pending;
                  end
                  r_state       <= ST_WAIT_MEM;
                  r_if_id_flush <= 1'b0;
                  r_id_ex_flush <= 1'b0;
               end
               ST_FLUSH: begin
                  // redirect_valid is deliberately not looked at here.
                  if (r_cnt == 3'd0) begin
                     r_state       <= ST_RUN;
                     r_if_id_flush <= 1'b0;
                     r_id_ex_flush <= 1'b0;
                  end else begin
                     r_cnt         <= r_cnt - 3'd1;
                     r_if_id_flush <= 1'b1;
                     r_id_ex_flush <= 1'b1;
                  end
               end
               default: begin
                  r_state       <= ST_RUN;
                  r_if_id_flush <= 1'b0;
                  r_id_ex_flush <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef REDIRECT_PERF_CNT_EN
   logic [31:0] r_redirect_count;

   // Saturating count of applied redirects; only reset clears it.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_redirect_count <= 32'd0;
      end else if (w_apply && (r_redirect_count != 32'hFFFF_FFFF)) begin
         r_redirect_count <= r_redirect_count + 32'd1;
      end else begin
         r_redirect_count <= r_redirect_count;
      end
   end

   assign redirect_count = r_redirect_count;
`else
   assign redirect_count = 32'd0;
`endif

   assign PC           = r_pc;
   assign pc_write_en  = w_pc_write_en;
   assign if_id_flush  = r_if_id_flush;
   assign id_ex_flush  = r_id_ex_flush;
   assign misalign_exc = r_misalign;
   assign state_dbg    = r_state;

endmodule

// File: tb/tb_pc_redirect_controller.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_controller
//
// Directed test of pc_redirect_controller with default parameters.
// Inputs change just after the falling edge. Outputs are checked on the
// falling edge, half a cycle away from the rising edge that updates them.
// ---------------------------------------------------------------------------
module tb_pc_redirect_controller;

   logic        CLK;
   logic        RESET;
   logic        stall;
   logic        imem_busy;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] PC;
   logic        pc_write_en;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        misalign_exc;
   logic [1:0]  state_dbg;
   logic [31:0] redirect_count;

   int n_checks = 0;
   int n_pass   = 0;

   pc_redirect_controller dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .stall           (stall),
      .imem_busy       (imem_busy),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .PC              (PC),
      .pc_write_en     (pc_write_en),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .misalign_exc    (misalign_exc),
      .state_dbg       (state_dbg),
      .redirect_count  (redirect_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Expected redirect_count after n applied redirects, for either build.
   function automatic logic [31:0] exp_cnt(input int n);
`ifdef REDIRECT_PERF_CNT_EN
      return 32'(n);
`else
      return 32'd0 + 32'(n - n);
`endif
   endfunction

   // Check PC, both flushes and the state in one go.
   task automatic check_cycle(input string tag, input logic [31:0] pc_e,
                              input logic fl_e, input logic [1:0] st_e);
      check({tag, ".pc"},     PC,                 pc_e);
      check({tag, ".ifid"},   32'(if_id_flush),   32'(fl_e));
      check({tag, ".idex"},   32'(id_ex_flush),   32'(fl_e));
      check({tag, ".state"},  32'(state_dbg),     32'(st_e));
   endtask

   initial begin
      RESET           = 1'b0;
      stall           = 1'b0;
      imem_busy       = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'd0;

      // Reset state
      @(negedge CLK);
      check_cycle("rst", 32'h0, 1'b0, 2'd0);
      check("rst.misalign", 32'(misalign_exc), 32'd0);
      check("rst.count", redirect_count, 32'd0);

      // Sequential advance 0,4,8,12,16
      RESET = 1'b1;
      @(negedge CLK); check_cycle("seq0", 32'h4, 1'b0, 2'd0);
      @(negedge CLK); check_cycle("seq1", 32'h8, 1'b0, 2'd0);
      @(negedge CLK); check_cycle("seq2", 32'hC, 1'b0, 2'd0);
      check("seq.misalign", 32'(misalign_exc), 32'd0);
      @(negedge CLK); check_cycle("seq3", 32'h10, 1'b0, 2'd0);

      // Single-cycle redirect at PC=0x10 to 0x40
      redirect_valid = 1'b1; redirect_target = 32'h40;
      #1 check("redir.wen", 32'(pc_write_en), 32'd1);
      @(negedge CLK); redirect_valid = 1'b0;
      check_cycle("redir0", 32'h40, 1'b1, 2'd2);
      @(negedge CLK); check_cycle("redir1", 32'h44, 1'b1, 2'd2);
      @(negedge CLK); check_cycle("redir2", 32'h48, 1'b0, 2'd0);
      check("redir.count", redirect_count, exp_cnt(1));

      // redirect_valid held for three cycles: only the first applies
      redirect_valid = 1'b1; redirect_target = 32'h40;
      @(negedge CLK); check_cycle("hold0", 32'h40, 1'b1, 2'd2);
      @(negedge CLK); check_cycle("hold1", 32'h44, 1'b1, 2'd2);
      @(negedge CLK); check_cycle("hold2", 32'h48, 1'b0, 2'd0);
      redirect_valid = 1'b0;
      check("hold.count", redirect_count, exp_cnt(2));

      // Redirect while memory is busy for three cycles
      redirect_valid = 1'b1; redirect_target = 32'h80; imem_busy = 1'b1;
      #1 check("busy.wen", 32'(pc_write_en), 32'd0);
      @(negedge CLK); redirect_valid = 1'b0;
      check_cycle("busy0", 32'h48, 1'b0, 2'd1);
      @(negedge CLK); check_cycle("busy1", 32'h48, 1'b0, 2'd1);
      @(negedge CLK); check_cycle("busy2", 32'h48, 1'b0, 2'd1);
      imem_busy = 1'b0;
      #1 check("busy.apply_wen", 32'(pc_write_en), 32'd1);
      @(negedge CLK); check_cycle("busy3", 32'h80, 1'b1, 2'd2);
      @(negedge CLK); check_cycle("busy4", 32'h84, 1'b1, 2'd2);
      @(negedge CLK); check_cycle("busy5", 32'h88, 1'b0, 2'd0);
      check("busy.count", redirect_count, exp_cnt(3));

      // Misaligned target traps to 0x4 with a one-cycle exception pulse
      redirect_valid = 1'b1; redirect_target = 32'h42;
      @(negedge CLK); redirect_valid = 1'b0;
      check_cycle("mis0", 32'h4, 1'b1, 2'd2);
      check("mis0.exc", 32'(misalign_exc), 32'd1);
      @(negedge CLK); check_cycle("mis1", 32'h8, 1'b1, 2'd2);
      check("mis1.exc", 32'(misalign_exc), 32'd0);
      @(negedge CLK); check_cycle("mis2", 32'hC, 1'b0, 2'd0);
      check("mis.count", redirect_count, exp_cnt(4));

      // Redirect beats a simultaneous stall; stall holds PC during FLUSH
      stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
      @(negedge CLK); redirect_valid = 1'b0;
      check_cycle("stl0", 32'h100, 1'b1, 2'd2);
      #1 check("stl.wen", 32'(pc_write_en), 32'd0);
      @(negedge CLK); stall = 1'b0;
      check_cycle("stl1", 32'h100, 1'b1, 2'd2);
      @(negedge CLK); check_cycle("stl2", 32'h104, 1'b0, 2'd0);
      check("stl.count", redirect_count, exp_cnt(5));

      // Plain stall in RUN
      stall = 1'b1;
      #1 check("run_stall.wen", 32'(pc_write_en), 32'd0);
      @(negedge CLK); stall = 1'b0;
      check_cycle("run_stall", 32'h104, 1'b0, 2'd0);

      // 32-bit wrap: 0xFFFFFFF8 -> FFFC -> 0
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
      @(negedge CLK); redirect_valid = 1'b0;
      check_cycle("wrap0", 32'hFFFF_FFF8, 1'b1, 2'd2);
      @(negedge CLK); check_cycle("wrap1", 32'hFFFF_FFFC, 1'b1, 2'd2);
      @(negedge CLK); check_cycle("wrap2", 32'h0, 1'b0, 2'd0);
      check("wrap.count", redirect_count, exp_cnt(6));

      // Reset asserted during FLUSH takes effect immediately
      redirect_valid = 1'b1; redirect_target = 32'h200;
      @(negedge CLK); redirect_valid = 1'b0;
      check_cycle("rf0", 32'h200, 1'b1, 2'd2);
      #2 RESET = 1'b0;
      #1 check_cycle("rf_rst", 32'h0, 1'b0, 2'd0);
      check("rf_rst.count", redirect_count, 32'd0);
      @(negedge CLK); RESET = 1'b1;
      check_cycle("rf_hold", 32'h0, 1'b0, 2'd0);
      @(negedge CLK); check_cycle("rf_run", 32'h4, 1'b0, 2'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
